vga_frame_capture: RTL and testbench
====================================

Name: vga_frame_capture

Overview:
- Receive-side counterpart of the VGA output path.
- Watches the outgoing video stream (vsync, data-enable, 12-bit RGB) on the pixel clock and rebuilds the pixel position from the sync and enable timing.
- Downsamples a square handwriting window into a 28x28 binary ink bitmap for the digit recogniser.
- Capture is on request; the bitmap is read back through a 1-cycle-latency read port.

Parameters:
- WIN_X, 208: first active column of the capture window.
- WIN_Y, 128: first active line of the capture window.
- CELL, 8: pixels per cell edge; must be a power of two.
- DIM, 28: cells per bitmap edge. The window spans CELL*DIM = 224 pixels.
- INK_THRESH, 6: a pixel is ink when R+G+B (6-bit sum) is below this value.

Ports:
- clka  in  1  pixel clock, one pixel per cycle while de=1.
- rst  in  1  reset, asynchronous, active-low.
- vsync  in  1  vertical sync, active-low pulse.
- de  in  1  data enable (active video).
- pixel_in  in  12  {R,G,B} 4 bits each.
- cap_req  in  1  single-cycle capture request.
- busy  out  1  high in ARMED and CAPTURE.
- cap_done  out  1  one-cycle pulse when a capture ends.
- cap_short  out  1  valid with cap_done: frame ended before row DIM-1 was committed.
- rd_addr  in  10  bitmap index, row*DIM+col, 0..783.
- rd_data  out  1  bitmap bit at rd_addr, registered.

Behaviour:
- Reset (rst=0, async): state=IDLE. busy, cap_done, cap_short, rd_data = 0. Counters, accumulator and the 784-bit bitmap cleared.
- Position tracking (always running):
  - x increments on every de=1 cycle and clears on de falling edge.
  - y increments on de falling edge.
  - x and y both clear while vsync=0.
  - First pixel after a vsync pulse is (0,0).
- Window test: WIN_X <= x < WIN_X+224 and WIN_Y <= y < WIN_Y+224. Use unsigned compares; widths are 10 bits.
- Cell column = (x-WIN_X)>>log2(CELL). Band row = (y-WIN_Y)>>log2(CELL).
- State machine:
  - IDLE: on cap_req, go to ARMED. busy=1 from the next cycle.
  - ARMED: wait for a vsync rising edge (0->1). In that cycle, clear the bitmap and accumulator and go to CAPTURE.
  - CAPTURE, per pixel: for each in-window ink pixel, set acc[cell col] (OR).
  - CAPTURE, per line: on de falling edge where (y-WIN_Y)%CELL == CELL-1 and y is in the window, write acc into bitmap row = band row and clear acc in the same cycle.
  - CAPTURE, completion: the cycle after row DIM-1 is written, pulse cap_done (cap_short=0) and return to IDLE.
  - CAPTURE, early frame end: if vsync falls before row DIM-1 is committed, pulse cap_done with cap_short=1 and return to IDLE. Committed rows are kept; the uncommitted accumulator is discarded.
- cap_req while busy is ignored. cap_req in the same cycle as cap_done is ignored.
- Read port:
  - rd_data is valid one cycle after rd_addr, in every state.
  - Reads during CAPTURE return the partial bitmap.
  - rd_addr > 783 returns 0.
- Reset mid-capture: immediate return to IDLE. Bitmap is cleared and no cap_done is produced.
- Ink sum is zero-extended to 6 bits before the compare.

Optional Feature:
- Macro: CAPTURE_BBOX_EN.
- When defined, add outputs bbox_valid (1), bbox_rmin, bbox_rmax, bbox_cmin, bbox_cmax (5 each):
  - The row/column extent of set cells, updated at each row commit.
  - bbox_valid=0 until the first set cell.
  - All bbox outputs clear at CAPTURE entry and at reset.
  - The values are stable from cap_done onward.
- When undefined, these ports and their logic do not exist. All other behaviour is identical.

Decomposition:
- Shared package vga_pkg holds:
  - 640x480 timing constants.
  - Capture window defaults WIN_X, WIN_Y, CELL, DIM.
  - The state typedef (IDLE, ARMED, CAPTURE).
  - Bitmap address width.
- One natural sub-module: vga_pos_tracker. It derives x, y, the de-fall strobe and the vsync edges from vsync/de. It is reusable by other stream consumers.

Test Plan:
- Frame of all-white pixels (12'hFFF) after cap_req -> cap_done=1, cap_short=0; all 784 rd_data reads return 0.
- A single black pixel at (WIN_X+17, WIN_Y+9) -> only bit 1*28+2 = 30 is set; cap_done arrives exactly 1 cycle after the de fall of line WIN_Y+223.
- vsync pulse injected after line WIN_Y+100 with an ink row at WIN_Y+50 -> cap_short=1; bit row 6 is set; rows 12..27 read 0.
- cap_req pulsed again during CAPTURE, and again while in ARMED -> exactly one cap_done; busy stays high continuously.
- rst driven low mid-CAPTURE, asynchronously between clock edges -> busy=0 immediately; rd_data=0 for every address afterwards; no cap_done.
- With CAPTURE_BBOX_EN: ink at cells (3,4) and (20,25) -> bbox_rmin=3, rmax=20, cmin=4, cmax=25, bbox_valid=1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA stream consumers: 640x480 timing,
// capture window defaults, capture state encoding and bitmap sizing.
package vga_pkg;

    // 640x480 @ 60 Hz timing, in pixel clocks / lines
    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Handwriting window defaults: a 224x224 square split into 28x28 cells
    localparam int WIN_X_DEF      = 208;
    localparam int WIN_Y_DEF      = 128;
    localparam int CELL_DEF       = 8;
    localparam int DIM_DEF        = 28;
    localparam int INK_THRESH_DEF = 6;

    // Pixel position counters cover the full 800x525 raster
    localparam int POS_W = 10;

    // Bitmap read address: row*DIM+col, 0..783
    localparam int BM_AW = 10;

    // Capture sequencing
    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t ARMED   = 2'd1;
    localparam state_t CAPTURE = 2'd2;

    // Index of the lowest set bit (0 when none is set)
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        lowest_set = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) lowest_set = 5'(i);
        end
    endfunction

    // Index of the highest set bit (0 when none is set)
    function automatic logic [4:0] highest_set(input logic [31:0] v);
        highest_set = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) highest_set = 5'(i);
        end
    endfunction

endpackage

// File: rtl/vga_pos_tracker.sv
// Rebuilds the raster position of a VGA stream from vsync and data-enable.
// x counts active pixels within a line, y counts completed active lines;
// both restart at 0 after each vsync pulse. Also provides the de-fall
// strobe and vsync edge strobes for downstream consumers.
module vga_pos_tracker
    import vga_pkg::*;
#(
    parameter int W = POS_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vsync,
    input  logic         de,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         de_fall,
    output logic         vs_rise,
    output logic         vs_fall
);

    logic de_d;
    logic vs_d;

    // Delayed copies of de and vsync for edge detection, plus the x/y counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_d <= 1'b0;
            vs_d <= 1'b1;   // sync idles high, so no false rise after reset
            x    <= '0;
            y    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            de_d <= de;
            vs_d <= vsync;
            if (!vsync) begin
                x <= '0;
                y <= '0;
            end else if (de) begin
                x <= x + 1'b1;
            end else if (de_d) begin
                x <= '0;
                y <= y + 1'b1;
            end
        end
    end

    // During the de-fall cycle y still names the line that just ended
    assign de_fall = de_d & ~de;
    assign vs_rise = ~vs_d & vsync;
    assign vs_fall = vs_d & ~vsync;

endmodule

// File: rtl/vga_frame_capture.sv
// Captures a 28x28 binary ink bitmap from a square window of the outgoing
// VGA stream on request. Each bitmap bit is the OR of "ink" pixels
// (R+G+B below INK_THRESH) inside one CELLxCELL cell. Rows are committed
// at the end of each cell band; the bitmap is read through a registered
// 1-cycle-latency port.
// Optional feature: define CAPTURE_BBOX_EN to add bounding-box outputs
// tracking the row/column extent of set cells.
module vga_frame_capture
    import vga_pkg::*;
#(
    parameter int WIN_X      = WIN_X_DEF,
    parameter int WIN_Y      = WIN_Y_DEF,
    parameter int CELL       = CELL_DEF,
    parameter int DIM        = DIM_DEF,
    parameter int INK_THRESH = INK_THRESH_DEF
) (
    input  logic             clka,
    input  logic             rst,
    input  logic             vsync,
    input  logic             de,
    input  logic [11:0]      pixel_in,
    input  logic             cap_req,
    output logic             busy,
    output logic             cap_done,
    output logic             cap_short,
    input  logic [BM_AW-1:0] rd_addr,
    output logic             rd_data
`ifdef CAPTURE_BBOX_EN
    ,
    output logic             bbox_valid,
    output logic [4:0]       bbox_rmin,
    output logic [4:0]       bbox_rmax,
    output logic [4:0]       bbox_cmin,
    output logic [4:0]       bbox_cmax
`endif
);

    localparam int CELL_SH = $clog2(CELL);
    localparam int IDX_W   = $clog2(DIM);
    localparam int SPAN    = CELL * DIM;
    localparam int BM_BITS = DIM * DIM;

    localparam logic [POS_W-1:0] X_LO      = POS_W'(WIN_X);
    localparam logic [POS_W-1:0] X_HI      = POS_W'(WIN_X + SPAN);
    localparam logic [POS_W-1:0] Y_LO      = POS_W'(WIN_Y);
    localparam logic [POS_W-1:0] Y_HI      = POS_W'(WIN_Y + SPAN);
    localparam logic [POS_W-1:0] CELL_MASK = POS_W'(CELL - 1);
    localparam logic [BM_AW-1:0] RD_LIMIT  = BM_AW'(BM_BITS);
    localparam logic [IDX_W-1:0] LAST_ROW  = IDX_W'(DIM - 1);

    logic [POS_W-1:0]   x, y, dx, dy;
    logic               de_fall, vs_rise, vs_fall;
    logic               x_in, y_in;
    logic [IDX_W-1:0]   col, band;
    logic [5:0]         ink_sum;
    logic               ink;
    logic               pix_hit, row_commit, last_commit, start_cap, early_end;
    state_t             state;
    logic [DIM-1:0]     acc;
    logic [BM_BITS-1:0] bitmap;

    vga_pos_tracker #(
        .W (POS_W)
    ) u_pos (
        .clk     (clka),
        .rst_n   (rst),
        .vsync   (vsync),
        .de      (de),
        .x       (x),
        .y       (y),
        .de_fall (de_fall),
        .vs_rise (vs_rise),
        .vs_fall (vs_fall)
    );

    // Window membership and cell coordinates (unsigned 10-bit compares)
    assign x_in = (x >= X_LO) && (x < X_HI);
    assign y_in = (y >= Y_LO) && (y < Y_HI);
    assign dx   = x - X_LO;
    assign dy   = y - Y_LO;
    assign col  = IDX_W'(dx >> CELL_SH);
    assign band = IDX_W'(dy >> CELL_SH);

    // Dark pixels are ink; channels are zero-extended before summing
    assign ink_sum = 6'(pixel_in[11:8]) + 6'(pixel_in[7:4]) + 6'(pixel_in[3:0]);
    assign ink     = ink_sum < 6'(INK_THRESH);

    assign busy        = (state == ARMED) || (state == CAPTURE);
    assign start_cap   = (state == ARMED) && vs_rise;
    assign pix_hit     = (state == CAPTURE) && de && x_in && y_in && ink;
    assign row_commit  = (state == CAPTURE) && de_fall && y_in
                         && ((dy & CELL_MASK) == CELL_MASK);
    assign last_commit = row_commit && (band == LAST_ROW);
    assign early_end   = (state == CAPTURE) && vs_fall && !last_commit;

    // Capture sequencing and the completion pulse
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cap_done  <= 1'b0;
            cap_short <= 1'b0;
        end else begin
            cap_done  <= 1'b0;
            cap_short <= 1'b0;
            case (state)
                IDLE: begin
                    // a request coinciding with the done pulse is dropped
                    if (cap_req && !cap_done) state <= ARMED;
                end
                ARMED: begin
                    if (vs_rise) state <= CAPTURE;
                end
                CAPTURE: begin
                    if (last_commit) begin
                        cap_done <= 1'b1;
                        state    <= IDLE;
                    end else if (early_end) begin
                        cap_done  <= 1'b1;
                        cap_short <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-band accumulator and bitmap row commits
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            // NOTE: bitmap is a flop array rather than RAM because it must clear in one cycle, both here and at capture start.
            acc    <= '0;
            bitmap <= '0;
        end else if (start_cap) begin
            acc    <= '0;
            bitmap <= '0;
        end else if (row_commit) begin
            bitmap[band*DIM +: DIM] <= acc;
            acc                     <= '0;
        end else if (early_end) begin
            acc <= '0;
        end else if (pix_hit) begin
            acc[col] <= 1'b1;
        end
    end

    // Registered read port; addresses past the bitmap read as 0
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            rd_data <= 1'b0;
        end else begin
            rd_data <= (rd_addr < RD_LIMIT) ? bitmap[rd_addr] : 1'b0;
        end
    end

`ifdef CAPTURE_BBOX_EN
    logic [4:0] acc_lo, acc_hi, band5;

    assign acc_lo = lowest_set(32'(acc));
    assign acc_hi = highest_set(32'(acc));
    assign band5  = 5'(band);

    // Extent of set cells, widened at each committed non-empty row
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            bbox_valid <= 1'b0;
            bbox_rmin  <= '0;
            bbox_rmax  <= '0;
            bbox_cmin  <= '0;
            bbox_cmax  <= '0;
        end else if (start_cap) begin
            bbox_valid <= 1'b0;
            bbox_rmin  <= '0;
            bbox_rmax  <= '0;
            bbox_cmin  <= '0;
            bbox_cmax  <= '0;
        end else if (row_commit && (|acc)) begin
            bbox_valid <= 1'b1;
            if (!bbox_valid) begin
                bbox_rmin <= band5;
                bbox_rmax <= band5;
                bbox_cmin <= acc_lo;
                bbox_cmax <= acc_hi;
            end else begin
                if (band5 < bbox_rmin)  bbox_rmin <= band5;
                if (band5 > bbox_rmax)  bbox_rmax <= band5;
                if (acc_lo < bbox_cmin) bbox_cmin <= acc_lo;
                if (acc_hi > bbox_cmax) bbox_cmax <= acc_hi;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_frame_capture.sv
// Self-checking bench for vga_frame_capture. Drives short synthetic frames
// (lines only as long as their rightmost listed pixel), keeps an
// independent bitmap model and compares read-back through a scoreboard.
module tb_vga_frame_capture;

    localparam int WX = 208;
    localparam int WY = 128;
    localparam int LAST_LINE = WY + 223;

    logic       clka = 1'b0;
    logic       rst;
    logic       vsync, de, cap_req;
    logic [11:0] pixel_in;
    logic       busy, cap_done, cap_short, rd_data;
    logic [9:0] rd_addr;
`ifdef CAPTURE_BBOX_EN
    logic       bbox_valid;
    logic [4:0] bbox_rmin, bbox_rmax, bbox_cmin, bbox_cmax;
`endif

    vga_frame_capture dut (
        .clka      (clka),
        .rst       (rst),
        .vsync     (vsync),
        .de        (de),
        .pixel_in  (pixel_in),
        .cap_req   (cap_req),
        .busy      (busy),
        .cap_done  (cap_done),
        .cap_short (cap_short),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
`ifdef CAPTURE_BBOX_EN
        ,
        .bbox_valid (bbox_valid),
        .bbox_rmin  (bbox_rmin),
        .bbox_rmax  (bbox_rmax),
        .bbox_cmin  (bbox_cmin),
        .bbox_cmax  (bbox_cmax)
`endif
    );

    always #5 clka = ~clka;

    typedef struct {
        int          x;
        int          y;
        logic [11:0] c;
    } ink_t;

    ink_t ink_q[$];
    bit   exp_bm [0:783];
    bit   exp_q[$];
    int   addr_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int done_short = 0;
    int fall_cyc = 0;
    int busy_drops = 0;
    bit watch_busy = 0;
    int req_line = -1;
    bit req_on_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clka) cyc++;

    // Output monitor: done pulses and continuity of busy
    always @(negedge clka) begin
        if (cap_done) begin
            done_cnt++;
            done_cyc   = cyc;
            done_short = int'(cap_short);
            watch_busy = 0;
        end else if (watch_busy && !busy) begin
            busy_drops++;
        end
    end

    task automatic step(input logic v, input logic d, input logic [11:0] p, input logic r);
        @(negedge clka);
        vsync    = v;
        de       = d;
        pixel_in = p;
        cap_req  = r;
    endtask

    function automatic logic [11:0] pixel_at(input int x, input int y);
        logic [11:0] c;
        c = 12'hFFF;
        foreach (ink_q[i]) if (ink_q[i].x == x && ink_q[i].y == y) c = ink_q[i].c;
        return c;
    endfunction

    function automatic int line_len(input int y);
        int m;
        m = 1;
        foreach (ink_q[i]) if (ink_q[i].y == y && ink_q[i].x + 1 > m) m = ink_q[i].x + 1;
        return m;
    endfunction

    task automatic vsync_pulse();
        repeat (3) step(1'b0, 1'b0, 12'hFFF, 1'b0);
        repeat (2) step(1'b1, 1'b0, 12'hFFF, 1'b0);
    endtask

    task automatic drive_lines(input int n);
        for (int yy = 0; yy < n; yy++) begin
            int len;
            len = line_len(yy);
            for (int xx = 0; xx < len; xx++)
                step(1'b1, 1'b1, pixel_at(xx, yy), (yy == req_line) && (xx == 0));
            for (int g = 0; g < 3; g++) begin
                step(1'b1, 1'b0, 12'hFFF, req_on_done && (yy == LAST_LINE) && (g == 1));
                if (g == 0 && yy == LAST_LINE) fall_cyc = cyc;
            end
        end
    endtask

    // Independent model: rows below commit_rows hold the OR of ink cells
    task automatic build_expected(input int commit_rows);
        int x, y, s;
        foreach (exp_bm[i]) exp_bm[i] = 1'b0;
        foreach (ink_q[i]) begin
            x = ink_q[i].x;
            y = ink_q[i].y;
            s = int'(ink_q[i].c[11:8]) + int'(ink_q[i].c[7:4]) + int'(ink_q[i].c[3:0]);
            if (x >= WX && x < WX + 224 && y >= WY && y < WY + 224 && s < 6
                && (y - WY) / 8 < commit_rows)
                exp_bm[((y - WY) / 8) * 28 + (x - WX) / 8] = 1'b1;
        end
    endtask

    task automatic sb_pop(input string tag);
        int  a;
        bit  e;
        a = addr_q.pop_front();
        e = exp_q.pop_front();
        check($sformatf("%s[%0d]", tag, a), 32'(rd_data), 32'(e));
    endtask

    // Read the whole map plus a few out-of-range addresses
    task automatic readback(input string tag);
        for (int a = 0; a < 788; a++) begin
            @(negedge clka);
            if (exp_q.size() > 0) sb_pop(tag);
            rd_addr = 10'(a);
            addr_q.push_back(a);
            exp_q.push_back((a < 784) ? exp_bm[a] : 1'b0);
        end
        @(negedge clka);
        sb_pop(tag);
    endtask

    task automatic request(input bit extra_armed_req);
        step(1'b1, 1'b0, 12'hFFF, 1'b1);
        step(1'b1, 1'b0, 12'hFFF, 1'b0);
        check("busy_after_req", 32'(busy), 32'd1);
        busy_drops = 0;
        watch_busy = 1;
        if (extra_armed_req) begin
            step(1'b1, 1'b0, 12'hFFF, 1'b1);
            step(1'b1, 1'b0, 12'hFFF, 1'b0);
        end
        vsync_pulse();
`ifdef CAPTURE_BBOX_EN
        check("bbox_valid_entry", 32'(bbox_valid), 32'd0);
`endif
    endtask

    task automatic full_capture(input string tag, input bit extra_armed_req);
        done_cnt = 0;
        request(extra_armed_req);
        drive_lines(LAST_LINE + 1);
        repeat (4) step(1'b1, 1'b0, 12'hFFF, 1'b0);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_short"}, 32'(done_short), 32'd0);
        check({tag, "_done_lat"}, 32'(done_cyc - fall_cyc), 32'd1);
        check({tag, "_busy_drops"}, 32'(busy_drops), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        build_expected(28);
        readback(tag);
        req_line    = -1;
        req_on_done = 0;
    endtask

    initial begin
        rst      = 1'b0;
        vsync    = 1'b1;
        de       = 1'b0;
        pixel_in = 12'hFFF;
        cap_req  = 1'b0;
        rd_addr  = '0;
        repeat (3) @(negedge clka);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(cap_done), 32'd0);
        check("rst_short", 32'(cap_short), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clka);

        // White frame (including a sum-of-6 grey), nothing set
        ink_q = {};
        ink_q.push_back('{WX, WY, 12'hFFF});
        ink_q.push_back('{WX + 100, WY + 100, 12'h222});
        ink_q.push_back('{WX + 223, WY + 223, 12'hFFF});
        full_capture("white", 1'b0);

        // Single black pixel -> bit 30
        ink_q = {};
        ink_q.push_back('{WX + 17, WY + 9, 12'h000});
        full_capture("single", 1'b0);

        // Window corners, outside pixels, threshold edge, request on done
        ink_q = {};
        ink_q.push_back('{WX, WY, 12'h000});
        ink_q.push_back('{WX + 223, WY + 223, 12'h000});
        ink_q.push_back('{WX - 1, WY + 8, 12'h000});
        ink_q.push_back('{WX + 224, WY + 16, 12'h000});
        ink_q.push_back('{WX + 50, WY - 1, 12'h000});
        ink_q.push_back('{WX + 40, WY + 40, 12'h221});
        ink_q.push_back('{WX + 48, WY + 48, 12'h222});
        ink_q.push_back('{WX + 70, WY + 90, 12'h005});
        req_on_done = 1;
        full_capture("edges", 1'b0);

        // Extra requests in ARMED and CAPTURE; ink at cells (3,4) and (20,25)
        ink_q = {};
        ink_q.push_back('{WX + 33, WY + 26, 12'h000});
        ink_q.push_back('{WX + 203, WY + 165, 12'h010});
        req_line = WY + 10;
        full_capture("multi", 1'b1);
`ifdef CAPTURE_BBOX_EN
        check("bbox_valid", 32'(bbox_valid), 32'd1);
        check("bbox_rmin", 32'(bbox_rmin), 32'd3);
        check("bbox_rmax", 32'(bbox_rmax), 32'd20);
        check("bbox_cmin", 32'(bbox_cmin), 32'd4);
        check("bbox_cmax", 32'(bbox_cmax), 32'd25);
`endif

        // Early vsync after line WY+100: rows 0..11 kept, partial band dropped
        ink_q = {};
        ink_q.push_back('{WX + 10, WY + 50, 12'h000});
        ink_q.push_back('{WX + 10, WY + 98, 12'h000});
        done_cnt = 0;
        request(1'b0);
        drive_lines(WY + 101);
        vsync_pulse();
        repeat (2) step(1'b1, 1'b0, 12'hFFF, 1'b0);
        check("short_done_cnt", 32'(done_cnt), 32'd1);
        check("short_flag", 32'(done_short), 32'd1);
        check("short_idle", 32'(busy), 32'd0);
        build_expected(12);
        readback("short");

        // Partial read mid-capture, then asynchronous reset
        ink_q = {};
        ink_q.push_back('{WX + 3, WY + 2, 12'h000});
        ink_q.push_back('{WX + 30, WY + 42, 12'h000});
        done_cnt = 0;
        request(1'b0);
        drive_lines(WY + 45);
        watch_busy = 0;
        build_expected(5);
        readback("partial");
        check("partial_busy", 32'(busy), 32'd1);
        @(negedge clka);
        #2 rst = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_rd", 32'(rd_data), 32'd0);
        repeat (3) @(negedge clka);
        rst = 1'b1;
        repeat (3) step(1'b1, 1'b0, 12'hFFF, 1'b0);
        check("post_rst_busy", 32'(busy), 32'd0);
        build_expected(0);
        readback("post_rst");
        check("post_rst_done_cnt", 32'(done_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
